// File: rtl/iomem_initiator.sv
// Bus-master end of the PicoSoC iomem interface: turns single valid/ready commands
// into one iomem request each. Define IOMEM_TIMEOUT_EN to abort stalled requests.
module iomem_initiator #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 16
) (
  input  logic             clk_pll,
  input  logic             resetn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_addr,
  input  logic [31:0]      cmd_wdata,
  input  logic [3:0]       cmd_wstrb,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_error,
  output logic             iomem_valid,
  input  logic             iomem_ready,
  output logic [3:0]       iomem_wstrb,
  output logic [31:0]      iomem_addr,
  output logic [31:0]      iomem_wdata,
  input  logic [31:0]      iomem_rdata,
  output logic             busy,
  output logic [CNT_W-1:0] done_count,
  output logic [1:0]       state_dbg
);

  // Handshakes: a transfer happens on a rising clk_pll edge where valid and ready
  // are both high; valid, once raised, is held with its payload until that edge.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   accept, complete, consume, tmo_expired;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range 1..65535");
  end

  // Byte offset within the word is dropped on the bus.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^cmd_addr[1:0];

  assign state_dbg = state_q;

  always_ff @(posedge clk_pll) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    complete = 1'b0;
    consume  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          accept  = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        // A ready in the same cycle as the timeout still completes normally.
        if (iomem_ready) begin
          complete = 1'b1;
          state_d  = RSP;
        end else if (tmo_expired) begin
          state_d  = RSP;
        end
      end
      RSP: begin
        if (rsp_valid && rsp_ready) begin
          consume = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_pll) begin
    if (!resetn) begin
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 32'h0;
      iomem_valid <= 1'b0;
      iomem_wstrb <= 4'h0;
      iomem_addr  <= 32'h0;
      iomem_wdata <= 32'h0;
      busy        <= 1'b0;
      done_count  <= '0;
    end else begin
      cmd_ready <= (state_d == IDLE);
      busy      <= (state_d != IDLE);
      if (accept) begin
        iomem_valid <= 1'b1;
        iomem_addr  <= {cmd_addr[31:2], 2'b00};
        iomem_wdata <= cmd_wdata;
        iomem_wstrb <= cmd_wstrb;
      end
      if (state_q == REQ && state_d == RSP) begin
        iomem_valid <= 1'b0;
        iomem_wstrb <= 4'h0;
        rsp_valid   <= 1'b1;
        rsp_rdata   <= complete ? iomem_rdata : 32'hFFFF_FFFF;
      end
      if (consume) begin
        rsp_valid  <= 1'b0;
        done_count <= done_count + CNT_W'(1);
      end
    end
  end

`ifdef IOMEM_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] tmo_cnt;

  // Counts REQ cycles that ended without ready; expiry is the last such cycle.
  assign tmo_expired = (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk_pll) begin
    if (!resetn) begin
      tmo_cnt   <= 16'h0;
      rsp_error <= 1'b0;
    end else begin
      if (accept) tmo_cnt <= 16'h0;
      else if (state_q == REQ && !iomem_ready) tmo_cnt <= tmo_cnt + 16'h1;
      if (state_q == REQ && state_d == RSP) rsp_error <= !complete;
    end
  end
`else
  assign tmo_expired = 1'b0;
  assign rsp_error   = 1'b0;
`endif

endmodule

// File: doc/iomem_initiator.md
Name: iomem_initiator

Overview:
- Bus-master end of the PicoSoC iomem interface; drives iomem_valid/addr/wdata/wstrb and waits for a responder's iomem_ready.
- Lets a non-CPU agent (debug bridge, test sequencer, DMA front end) perform single 32-bit reads/writes on the same peripheral bus the SoC uses.
- Command in and response out are each valid/ready handshakes; one transaction outstanding at a time.

Parameters:
- TIMEOUT_CYCLES, 255: max cycles iomem_valid is held without iomem_ready before abort (used only with IOMEM_TIMEOUT_EN); legal range 1..65535.
- CNT_W, 16: width of the completed-transaction counter.

Ports:
- clk_pll  in  1  clock; all logic on posedge.
- resetn  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_addr  in  32  byte address.
- cmd_wdata  in  32  write data.
- cmd_wstrb  in  4  byte enables; 4'b0000 = read.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_rdata  out  32  data returned by the responder.
- rsp_error  out  1  transaction aborted by timeout.
- iomem_valid  out  1  bus request.
- iomem_ready  in  1  bus acknowledge (single-cycle pulse from responder).
- iomem_wstrb  out  4  bus byte enables.
- iomem_addr  out  32  bus address, word aligned.
- iomem_wdata  out  32  bus write data.
- iomem_rdata  in  32  bus read data, valid in the iomem_ready cycle.
- busy  out  1  high in REQ or RSP.
- done_count  out  CNT_W  completed responses, wraps modulo 2^CNT_W.

Behaviour:
- All outputs registered. Reset values: cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_error=0, iomem_valid=0, iomem_wstrb=0, iomem_addr=0, iomem_wdata=0, busy=0, done_count=0. State goes to IDLE.
- On the first cycle after reset deasserts, cmd_ready becomes 1.
- FSM states: IDLE, REQ, RSP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid & cmd_ready: register iomem_addr={cmd_addr[31:2],2'b00}, iomem_wdata=cmd_wdata, iomem_wstrb=cmd_wstrb. Set iomem_valid=1, cmd_ready=0, go to REQ.
  - cmd_addr[1:0] is discarded.
- REQ:
  - iomem_valid, addr, wdata and wstrb are held stable.
  - On a cycle where iomem_ready=1: capture rsp_rdata=iomem_rdata. Next cycle iomem_valid=0 and iomem_wstrb=0, rsp_valid=1, rsp_error=0; go to RSP.
  - iomem_valid never stays high for the cycle after ready is sampled, so the responder never sees a second request.
- RSP:
  - rsp_valid held, with rsp_rdata and rsp_error stable, until rsp_ready.
  - On rsp_valid & rsp_ready: rsp_valid=0, done_count+1, cmd_ready=1, go to IDLE.
- Writes also return iomem_rdata as sampled; its content is responder-defined.
- iomem_ready seen in IDLE or RSP is ignored.
- Minimum latency, with a responder that asserts ready one cycle after valid:
  - command accepted at edge N;
  - iomem_valid high from N+1;
  - ready sampled at N+2;
  - rsp_valid high from N+3.
  - Back-to-back throughput: one transaction per 4 cycles with rsp_ready tied high.
- A responder may insert arbitrary wait cycles; the block waits.
- done_count wraps from 2^CNT_W-1 to 0.
- Reset mid-transaction: abandon immediately; iomem_valid=0 on the next edge; no response is produced.

Optional Feature:
- Macro: IOMEM_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQ and increments every REQ cycle without iomem_ready.
  - When it reaches TIMEOUT_CYCLES, next cycle: iomem_valid=0, rsp_valid=1, rsp_error=1, rsp_rdata=32'hFFFF_FFFF; go to RSP.
  - If iomem_ready arrives in the same cycle the count reaches TIMEOUT_CYCLES, ready wins (normal completion, rsp_error=0).
  - A timed-out response increments done_count.
- Not defined: no counter logic; REQ waits indefinitely; rsp_error is constant 0.

Test Plan:
- Write: cmd addr=0x0300_0004, wdata=0x1234_5678, wstrb=4'hF; responder ready 1 cycle after valid.
  -> iomem_addr=0x0300_0004, wstrb=F held until ready; rsp_valid at N+3; done_count=1.
- Read, misaligned: cmd addr=0x0400_0003, wstrb=0; responder returns 0x00AB_CDEF.
  -> iomem_addr=0x0400_0000; rsp_rdata=0x00AB_CDEF, rsp_error=0.
- Slow responder plus back-pressure: ready after 20 cycles; rsp_ready low for 5 cycles.
  -> iomem_valid high for exactly 20 cycles then low; rsp_valid held 5+ cycles with stable data; cmd_ready=0 throughout.
- Timeout (IOMEM_TIMEOUT_EN, TIMEOUT_CYCLES=8): responder never readies.
  -> iomem_valid drops after 8 cycles; rsp_error=1, rsp_rdata=0xFFFF_FFFF.
  -> Repeat with ready exactly at count 8: rsp_error=0.
- Reset mid-op: assert resetn=0 while in REQ.
  -> next edge iomem_valid=0, rsp_valid=0, done_count=0; a stray late iomem_ready produces no response.
- Wrap: CNT_W=4, 17 transactions -> done_count=1.
